sdm_cic_decimator: RTL and testbench
====================================

Name: sdm_cic_decimator

Overview:
- Receive-side counterpart of the team's 16-bit sigma-delta modulator, which turns signed PCM into a 1-bit stream.
- This block takes that 1-bit stream and reconstructs signed 16-bit PCM.
- Structure: 3rd-order CIC (sinc3) decimator, OSR-fold decimation, then output scaling and saturation.
- Sits directly after the modulator in loopback benches, and after the bitstream capture path on hardware.

Parameters:
- LOG2_OSR, 6, log2 of the decimation ratio (OSR = 64). Legal range 4..10.
- OUT_W, 16, width of the PCM output.
- ACC_W, 3*LOG2_OSR+2, integrator/comb width. Derived; do not override.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  bit strobe; din is consumed only in cycles where en=1.
- din  in  1  modulator bitstream; 1 maps to +1, 0 maps to -1.
- dout  out  OUT_W  signed decimated PCM sample.
- dout_valid  out  1  one-cycle pulse marking a new dout.

Behaviour:
- Reset (async assert, sync release):
  - all integrators, comb delays and the decimation counter cleared;
  - dout=0, dout_valid=0.
- Input mapping: x = din ? +1 : -1, sign-extended to ACC_W.
- Integrators:
  - three cascaded, ACC_W bits: i1+=x, i2+=i1, i3+=i2;
  - update only when en=1;
  - two's-complement wrap is intentional; no saturation inside the CIC.
- Decimation counter:
  - cnt runs 0..OSR-1, increments on en=1, wraps to 0;
  - the en=1 cycle with cnt==OSR-1 is the "frame edge".
- Comb stage:
  - in the cycle after a frame edge, i3 is fed through three combs (c_k = y_{k-1} - delay_k, differential delay 1), all combinational in that one cycle;
  - comb delay registers update at the end of that same cycle.
- Output register, loaded at the end of the comb cycle:
  - dout = sat(comb3 >>> (3*LOG2_OSR-OUT_W+1)), arithmetic shift;
  - saturation bounds: [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- dout_valid:
  - high for exactly one clk, in the second cycle after the frame edge;
  - otherwise low; dout holds its value between pulses.
- Gain:
  - CIC gain is OSR^3 = 2^(3*LOG2_OSR); full scale ±1 input gives ±2^18 at OSR=64;
  - after the >>>3 shift: all-ones → +32768, saturated to 32767; all-zeros → -32768, exact.
- Settling: the first 3 dout samples after reset are transient (CIC fill); the fourth onward is exact.
- Rate: dout_valid period = OSR enabled cycles. With en constantly high, the period is exactly OSR clocks.
- en low: all state frozen, including a pending frame. A frame edge still completes its comb/output pipeline on the following cycles regardless of en.
- Reset mid-frame: partial frame discarded, cnt restarts at 0, and any pending dout_valid is suppressed.
- No backpressure: the consumer must accept dout on the dout_valid cycle.

Decomposition:
- Package sdm_pkg holds:
  - OUT_W default;
  - the function computing ACC_W and the output shift from LOG2_OSR;
  - signed PCM typedef pcm_t (OUT_W bits);
  - saturation helper function sat_pcm.
- The modulator and this decimator share sdm_pkg.
- One natural sub-module: cic_integrator (single ACC_W accumulator with enable), instantiated three times.
- Combs stay inline; they are a single-cycle datapath with three delay registers.

Test Plan:
- Reset: assert rst for 3 clk, en=0 → dout=0, dout_valid=0 throughout. Release, 100 clk with en=0 → no dout_valid.
- Full scale (en=1, din=1 constant):
  - dout_valid every 64 clk, first pulse 65 clk after the first enabled edge;
  - from the 4th pulse on, dout=32767 (saturated);
  - repeat with din=0 → dout=-32768.
- Half scale:
  - din pattern 1,1,1,0 repeating → settled dout=16384 (0x4000);
  - pattern 1,0 → settled dout=0;
  - pattern 1,0,0,0 → settled dout=-16384.
- Gated rate: en toggling 1,0 with din=1 constant → dout_valid period 128 clk; settled dout=32767; values identical to the en=1 run.
- Reset mid-frame: feed 30 bits of 1,1,1,0, pulse rst, resume → dout_valid first after 64 enabled cycles; settled value 16384 within 4 frames.
- Loopback: the team's modulator driven with din=16'h4000, this block on its output, LOG2_OSR=6 → settled dout within ±64 of 16384. Check dout_valid never asserts in consecutive cycles.

Source files
------------

// File: rtl/sdm_pkg.sv
// Shared definitions for the sigma-delta modulator and the sinc3 decimator:
// derived CIC sizing, the PCM sample type and output saturation.
package sdm_pkg;

  localparam int OUT_W_DEFAULT = 16;
  localparam int SAT_W         = 64;

  typedef logic signed [OUT_W_DEFAULT-1:0] pcm_t;

  // Integrator width: three stages of growth (3*LOG2_OSR) plus sign and one guard bit
  function automatic int cic_acc_w(input int log2_osr);
    return 32'sd3 * log2_osr + 32'sd2;
  endfunction

  // Right shift taking the 2^(3*LOG2_OSR) CIC gain back to OUT_W; negative means a left shift
  function automatic int cic_out_shift(input int log2_osr, input int out_w);
    return 32'sd3 * log2_osr - out_w + 32'sd1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_pcm(input logic signed [SAT_W-1:0] v,
                                                      input int out_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] r;
    hi = (64'sd1 <<< (out_w - 32'sd1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 32'sd1));
    if (v > hi) begin
      r = hi;
    end else if (v < lo) begin
      r = lo;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdm_cic_decimator_integrator.sv
// Single CIC integrator stage: an enabled W-bit accumulator whose
// two's-complement wrap is relied upon by the downstream combs.
module cic_integrator
  import sdm_pkg::*;
#(
  parameter int W = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [W-1:0] d,
  output logic signed [W-1:0] acc
);

  logic signed [W-1:0] acc_r;

  // Running sum of d, advancing only on enabled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= {W{1'b0}};
    end else if (en) begin
      acc_r <= acc_r + d;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/sdm_cic_decimator.sv
// Sinc3 CIC decimator: 1-bit sigma-delta stream in, OSR-decimated, scaled and
// saturated signed PCM out with a one-cycle valid strobe.
module sdm_cic_decimator
  import sdm_pkg::*;
#(
  parameter int LOG2_OSR = 6,
  parameter int OUT_W    = OUT_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_valid
);

  localparam int ACC_W = cic_acc_w(LOG2_OSR);
  localparam int SHIFT = cic_out_shift(LOG2_OSR, OUT_W);
  localparam int RSH   = (SHIFT > 0) ? SHIFT : 0;
  localparam int LSH   = (SHIFT < 0) ? -SHIFT : 0;

  localparam logic [LOG2_OSR-1:0]     CNT_LAST = {LOG2_OSR{1'b1}};
  localparam logic [LOG2_OSR-1:0]     CNT_ONE  = {{(LOG2_OSR-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] X_POS    = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] X_NEG    = {ACC_W{1'b1}};

  logic [LOG2_OSR-1:0]     cnt_r;
  logic                    frame_r;
  logic                    frame_edge_s;
  logic signed [ACC_W-1:0] x_s;
  logic signed [ACC_W-1:0] i1_s;
  logic signed [ACC_W-1:0] i2_s;
  logic signed [ACC_W-1:0] i3_s;
  logic signed [ACC_W-1:0] c1_s;
  logic signed [ACC_W-1:0] c2_s;
  logic signed [ACC_W-1:0] c3_s;
  logic signed [ACC_W-1:0] d1_r;
  logic signed [ACC_W-1:0] d2_r;
  logic signed [ACC_W-1:0] d3_r;
  logic signed [SAT_W-1:0] scaled_s;
  logic signed [OUT_W-1:0] dout_r;
  logic                    dout_valid_r;

  // Map the bitstream to +/-1 and flag the last enabled sample of each frame
  always_comb begin
    x_s          = X_NEG;
    frame_edge_s = 1'b0;
    if (din) begin
      x_s = X_POS;
    end else begin
      x_s = X_NEG;
    end
    if (en && (cnt_r == CNT_LAST)) begin
      frame_edge_s = 1'b1;
    end else begin
      frame_edge_s = 1'b0;
    end
  end

  cic_integrator #(.W(ACC_W)) u_int1 (.clk(clk), .rst(rst), .en(en), .d(x_s),  .acc(i1_s));
  cic_integrator #(.W(ACC_W)) u_int2 (.clk(clk), .rst(rst), .en(en), .d(i1_s), .acc(i2_s));
  cic_integrator #(.W(ACC_W)) u_int3 (.clk(clk), .rst(rst), .en(en), .d(i2_s), .acc(i3_s));

  // Three cascaded combs and gain removal; wrapped differences recover the true value
  always_comb begin
    c1_s     = i3_s - d1_r;
    c2_s     = c1_s - d2_r;
    c3_s     = c2_s - d3_r;
    scaled_s = ($signed({{(SAT_W-ACC_W){c3_s[ACC_W-1]}}, c3_s}) >>> RSH) <<< LSH;
  end

  // Decimation counter, frozen while en is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {LOG2_OSR{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Comb cycle follows the frame edge unconditionally; output lands one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_r      <= 1'b0;
      d1_r         <= {ACC_W{1'b0}};
      d2_r         <= {ACC_W{1'b0}};
      d3_r         <= {ACC_W{1'b0}};
      dout_r       <= {OUT_W{1'b0}};
      dout_valid_r <= 1'b0;
    end else begin
      frame_r      <= frame_edge_s;
      dout_valid_r <= frame_r;
      if (frame_r) begin
        d1_r   <= i3_s;
        d2_r   <= c1_s;
        d3_r   <= c2_s;
        dout_r <= OUT_W'(sat_pcm(scaled_s, OUT_W));
      end else begin
        d1_r   <= d1_r;
        d2_r   <= d2_r;
        d3_r   <= d3_r;
        dout_r <= dout_r;
      end
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;

endmodule

// File: tb/tb_sdm_cic_decimator.sv
// Directed bench for sdm_cic_decimator at OSR=64, OUT_W=16.
module tb_sdm_cic_decimator;
  import sdm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic din;
  pcm_t dout;
  logic dout_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int consec = 0;
  logic prev_v = 1'b0;
  int mod_err;
  int pulse_t[$];
  logic signed [15:0] pulse_v[$];

  always #5 clk = ~clk;

  sdm_cic_decimator #(.LOG2_OSR(6), .OUT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .dout(dout), .dout_valid(dout_valid)
  );

  always @(negedge clk) begin
    prev_v <= dout_valid;
    if (dout_valid && prev_v) consec <= consec + 1;
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    en = 1'b0;
    din = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_dout", dout, 0);
      check("rst_valid", dout_valid, 0);
    end
    rst = 1'b0;
  endtask

  // Drive ncyc clocks; loop index i of each observed pulse is recorded
  task automatic run(input int ncyc, input logic [3:0] pat, input int plen,
                     input bit gate, input bit use_mod);
    int k = 0;
    pulse_t.delete();
    pulse_v.delete();
    mod_err = 0;
    for (int i = 0; i < ncyc; i++) begin
      en = gate ? (i % 2 == 0) : 1'b1;
      if (use_mod) din = (mod_err >= 0);
      else din = pat[k % plen];
      @(posedge clk); #1;
      if (en) begin
        if (use_mod) mod_err += 16384 - (din ? 32768 : -32768);
        k++;
      end
      if (dout_valid) begin
        pulse_t.push_back(i);
        pulse_v.push_back(dout);
      end
    end
    en = 1'b0;
  endtask

  task automatic check_run(input string tag, input int n_exp, input int t_first,
                           input int period, input int settled);
    check({tag, "_npulse"}, pulse_t.size(), n_exp);
    if (pulse_t.size() > 0) check({tag, "_first_t"}, pulse_t[0], t_first);
    for (int j = 1; j < pulse_t.size(); j++)
      check({tag, "_period"}, pulse_t[j] - pulse_t[j-1], period);
    for (int j = 3; j < pulse_v.size(); j++)
      check({tag, "_settled"}, pulse_v[j], settled);
    check({tag, "_hold"}, dout, settled);
  endtask

  initial begin
    int nv;
    rst = 1'b1;
    en = 1'b0;
    din = 1'b0;

    do_reset();
    nv = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (dout_valid) nv++;
    end
    check("idle_novalid", nv, 0);
    check("idle_dout", dout, 0);

    // Full scale positive: transients i3 = C(64,3) and C(128,3)-based comb outputs >>> 3
    run(388, 4'b1111, 1, 1'b0, 1'b0);
    check_run("fs_pos", 6, 64, 64, 32767);
    if (pulse_v.size() > 1) begin
      check("fs_pos_s1", pulse_v[0], 5208);
      check("fs_pos_s2", pulse_v[1], 27048);
    end

    do_reset();
    run(388, 4'b0000, 1, 1'b0, 1'b0);
    check_run("fs_neg", 6, 64, 64, -32768);
    if (pulse_v.size() > 1) begin
      check("fs_neg_s1", pulse_v[0], -5208);
      check("fs_neg_s2", pulse_v[1], -27048);
    end

    do_reset();
    run(388, 4'b0111, 4, 1'b0, 1'b0);
    check_run("half_pos", 6, 64, 64, 16384);

    do_reset();
    run(388, 4'b0101, 2, 1'b0, 1'b0);
    check_run("zero", 6, 64, 64, 0);

    do_reset();
    run(388, 4'b0001, 4, 1'b0, 1'b0);
    check_run("half_neg", 6, 64, 64, -16384);

    // en toggling: half the sample rate, identical values
    do_reset();
    run(770, 4'b1111, 1, 1'b1, 1'b0);
    check_run("gated", 6, 127, 128, 32767);
    if (pulse_v.size() > 1) begin
      check("gated_s1", pulse_v[0], 5208);
      check("gated_s2", pulse_v[1], 27048);
    end

    // Reset arriving just after a frame edge must suppress the pending pulse
    do_reset();
    run(64, 4'b1111, 1, 1'b0, 1'b0);
    check("pend_npulse", pulse_t.size(), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("pend_valid0", dout_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("pend_valid1", dout_valid, 0);
    check("pend_dout", dout, 0);

    // Reset mid-frame, then resume from a fresh frame
    do_reset();
    run(30, 4'b0111, 4, 1'b0, 1'b0);
    check("mid_npulse", pulse_t.size(), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    run(388, 4'b0111, 4, 1'b0, 1'b0);
    check_run("midrst", 6, 64, 64, 16384);

    // Loopback from a first-order modulator model at input 0x4000
    do_reset();
    run(388, 4'b0000, 1, 1'b0, 1'b1);
    check("loop_npulse", pulse_t.size(), 6);
    for (int j = 3; j < pulse_v.size(); j++)
      check("loop_range", (pulse_v[j] >= 16320 && pulse_v[j] <= 16448), 1);

    check("no_consec_valid", consec, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
